// File: rtl/sr_cmd_conditioner_if.sv
// Command bus between the raw request source and the SR command conditioner.
// master drives the raw requests; slave (the conditioner) returns clean pulses and levels.
interface sr_cmd_conditioner_if;
    logic set_in;
    logic clr_in;
    logic s;
    logic r;
    logic set_level;
    logic clr_level;
    logic conflict;

    modport master (output set_in, clr_in,
                    input  s, r, set_level, clr_level, conflict);
    modport slave  (input  set_in, clr_in,
                    output s, r, set_level, clr_level, conflict);
endinterface

// File: rtl/sr_cmd_conditioner.sv
// Synchronizes and debounces raw set/clear requests, then turns accepted rises
// into single-cycle s/r pulses that can never be high together.
module sr_cmd_chan #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic res,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   level_dly_q;
    logic                   differ;

    assign differ = sync_q[SYNC_STAGES-1] != level_q;

    // Any sample matching the current level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (differ) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~level_dly_q;
endmodule

module sr_cmd_conditioner #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 4,
    parameter int CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 res,
    sr_cmd_conditioner_if.slave  bus
);
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       cf_q, cf_d;

    // Channel 0 is set, channel 1 is clear.
    assign raw = {bus.clr_in, bus.set_in};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        sr_cmd_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CNT(DEBOUNCE_CNT),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk    (clk),
            .res    (res),
            .raw_i  (raw[g]),
            .level_o(lvl[g]),
            .rise_o (rise[g])
        );
    end

    // Coincident rises are reported as a conflict instead of an illegal s=r=1.
    always_comb begin
        s_d  = rise[0] & ~rise[1];
        r_d  = rise[1] & ~rise[0];
        cf_d = rise[0] &  rise[1];
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s_q  <= 1'b0;
            r_q  <= 1'b0;
            cf_q <= 1'b0;
        end else begin
            s_q  <= s_d;
            r_q  <= r_d;
            cf_q <= cf_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.conflict  = cf_q;
    assign bus.set_level = lvl[0];
    assign bus.clr_level = lvl[1];
endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Bench for sr_cmd_conditioner: directed vector table, hand-written corner
// sequences and random bouncing stimulus against a window-based reference model.
module tb_sr_cmd_conditioner;
    localparam int N = 10000;

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    sr_cmd_conditioner_if ifa();
    sr_cmd_conditioner_if ifb();
    sr_cmd_conditioner_if ifc();

    assign ifb.set_in = ifa.set_in;
    assign ifb.clr_in = ifa.clr_in;
    assign ifc.set_in = ifa.set_in;
    assign ifc.clr_in = ifa.clr_in;

    sr_cmd_conditioner u_dut (.clk(clk), .res(res), .bus(ifa));
    sr_cmd_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CNT(1), .CNT_W(8))
        u_alt1 (.clk(clk), .res(res), .bus(ifb));
    sr_cmd_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CNT(8), .CNT_W(4))
        u_alt2 (.clk(clk), .res(res), .bus(ifc));

    // {s, r, conflict, set_level, clr_level}
    logic [4:0] act [3];
    assign act[0] = {ifa.s, ifa.r, ifa.conflict, ifa.set_level, ifa.clr_level};
    assign act[1] = {ifb.s, ifb.r, ifb.conflict, ifb.set_level, ifb.clr_level};
    assign act[2] = {ifc.s, ifc.r, ifc.conflict, ifc.set_level, ifc.clr_level};

    int total = 0;
    int bad   = 0;
    int nprint = 0;

    task automatic check(input string nm, input logic [4:0] a, input logic [4:0] e);
        total++;
        if (a !== e) begin
            bad++;
            if (nprint < 40) begin
                nprint++;
                $display("FAIL %s at %0t: got=%b want=%b", nm, $time, a, e);
            end
        end
    endtask

    task automatic step(input bit si, input bit ci);
        ifa.set_in = si;
        ifa.clr_in = ci;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        res = 1'b0;
        ifa.set_in = 1'b0;
        ifa.clr_in = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) check($sformatf("rst_state%0d", c), act[c], 5'b0);
        res = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        bit         si;
        bit         ci;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic void push(bit rst, bit si, bit ci,
                                 bit es, bit er, bit ec, bit esl, bit ecl);
        vec_t v;
        v.rst = rst; v.si = si; v.ci = ci;
        v.exp = {es, er, ec, esl, ecl};
        tbl.push_back(v);
    endfunction

    // Reference model: a level flips once the last D consumed samples all
    // disagree with it; a sample reaches the debouncer S edges after capture.
    int  cfg_s [3] = '{2, 3, 2};
    int  cfg_d [3] = '{4, 1, 8};
    bit  raw_s [0:N];
    bit  raw_c [0:N];
    bit  ls [3][0:N];
    bit  lc [3][0:N];

    function automatic bit cons(bit ch, int j, int S);
        int idx = j - S;
        if (idx < 1) return 1'b0;
        return ch ? raw_c[idx] : raw_s[idx];
    endfunction

    function automatic bit lvl_next(bit ch, bit cur, int k, int S, int D);
        for (int j = k - D + 1; j <= k; j++)
            if (cons(ch, j, S) == cur) return cur;
        return ~cur;
    endfunction

    initial begin
        int  cnt, first;
        bit  seen;
        bit  vs, vc;
        int  rem_s, rem_c;
        int  spulse [3];
        int  srise [3];
        bit  psl [3];
        bit  pcl [3];

        ifa.set_in = 1'b0;
        ifa.clr_in = 1'b0;
        @(negedge clk);

        // Clean press, simultaneous press, staggered press (defaults S=2, D=4).
        for (int i = 1; i <= 9; i++)  push(i == 1, 1, 0, i == 7, 0, 0, i >= 6, 0);
        for (int i = 1; i <= 9; i++)  push(i == 1, 1, 1, 0, 0, i == 7, i >= 6, i >= 6);
        for (int i = 1; i <= 11; i++) push(i == 1, 1, i >= 3, i == 7, i == 9, 0, i >= 6, i >= 8);
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].si, tbl[i].ci);
            check($sformatf("vec%0d", i), act[0], tbl[i].exp);
        end

        // Bounce on clear: 3 high, 1 low, 2 high, then low -- never accepted.
        do_reset();
        seen = 1'b0;
        begin
            bit pat [12] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
            foreach (pat[i]) begin
                step(1'b0, pat[i]);
                seen |= ifa.r | ifa.clr_level;
            end
        end
        check("bounce_quiet", {4'b0, seen}, 5'b0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            cnt += ifa.r;
        end
        check("held_one_r", 5'(cnt), 5'd1);
        check("held_clr_level", {4'b0, ifa.clr_level}, 5'd1);

        // Reset between edges in the middle of a pulse.
        do_reset();
        repeat (7) step(1'b1, 1'b0);
        check("pulse_before_rst", act[0], 5'b10010);
        #2 res = 1'b0;
        #1 check("async_rst_mid_pulse", act[0], 5'b0);
        @(negedge clk);
        res = 1'b1;

        // Reset mid-debounce with set held through reset and release.
        do_reset();
        repeat (4) step(1'b1, 1'b0);
        #2 res = 1'b0;
        #1 check("async_rst_mid_db", act[0], 5'b0);
        @(negedge clk);
        res = 1'b1;
        cnt = 0;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0);
            if (ifa.s) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        check("release_s_edge", 5'(first), 5'd7);
        check("release_s_count", 5'(cnt), 5'd1);

        // Random bouncing stimulus on all three configurations.
        do_reset();
        vs = 0; vc = 0; rem_s = 0; rem_c = 0;
        for (int c = 0; c < 3; c++) begin
            ls[c][0] = 0; lc[c][0] = 0;
            spulse[c] = 0; srise[c] = 0; psl[c] = 0; pcl[c] = 0;
        end
        raw_s[0] = 0; raw_c[0] = 0;
        for (int k = 1; k <= N; k++) begin
            if (rem_s == 0) begin vs = ~vs; rem_s = $urandom_range(1, 12); end
            if (rem_c == 0) begin vc = ~vc; rem_c = $urandom_range(1, 12); end
            rem_s--; rem_c--;
            raw_s[k] = vs;
            raw_c[k] = vc;
            step(vs, vc);
            for (int c = 0; c < 3; c++) begin
                bit rs, rc;
                ls[c][k] = lvl_next(1'b0, ls[c][k-1], k, cfg_s[c], cfg_d[c]);
                lc[c][k] = lvl_next(1'b1, lc[c][k-1], k, cfg_s[c], cfg_d[c]);
                rs = (k >= 2) ? (ls[c][k-1] & ~ls[c][k-2]) : 1'b0;
                rc = (k >= 2) ? (lc[c][k-1] & ~lc[c][k-2]) : 1'b0;
                check($sformatf("rnd_cfg%0d", c), act[c],
                      {rs & ~rc, rc & ~rs, rs & rc, ls[c][k], lc[c][k]});
                check($sformatf("inv_excl%0d", c),
                      {3'b0, act[c][4] & act[c][3], act[c][2] & (act[c][4] | act[c][3])}, 5'b0);
                if (k >= 2) spulse[c] += act[c][4];
                if (k < N && act[c][1] && !psl[c] && !(act[c][0] && !pcl[c])) srise[c]++;
                psl[c] = act[c][1];
                pcl[c] = act[c][0];
            end
        end
        for (int c = 0; c < 3; c++)
            check($sformatf("pulse_vs_rise%0d", c), 5'(spulse[c] - srise[c]), 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_cmd_conditioner.md
Name: sr_cmd_conditioner

Overview:
Upstream stage for the SR flip-flop.
- Takes two raw, asynchronous, possibly bouncing command inputs (set request, clear request).
- Synchronizes and debounces each one.
- Emits clean single-cycle s / r pulses that feed the SR flip-flop's s and r inputs directly.
- Guarantees the illegal s=r=1 combination is never presented downstream; a simultaneous request is flagged as a conflict instead.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per input; legal range is 2 or more.
- DEBOUNCE_CNT, 4, consecutive cycles a synchronized input must differ from its debounced level before the level changes; legal range is 1 or more.
- CNT_W, 8, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CNT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- res  input  1  asynchronous reset, active-low; res=0 clears all state immediately.
- set_in  input  1  raw set request, asynchronous to clk.
- clr_in  input  1  raw clear request, asynchronous to clk.
- s  output  1  one-cycle set pulse to the SR flip-flop.
- r  output  1  one-cycle reset pulse to the SR flip-flop.
- set_level  output  1  debounced level of set_in.
- clr_level  output  1  debounced level of clr_in.
- conflict  output  1  one-cycle pulse when set and clear rise in the same cycle.

Behaviour:
- Reset (res=0, asynchronous):
  - Sync chains, counters, debounced levels, previous-level registers, s, r and conflict all go to 0.
  - Nothing is produced while res=0.
- Synchronizer:
  - Each input passes through SYNC_STAGES flops.
  - The last stage is sync_set / sync_clr.
- Debounce, per channel, at each clk edge:
  - If sync != level and cnt == DEBOUNCE_CNT-1: level <= sync, cnt <= 0.
  - Else if sync != level: cnt <= cnt+1.
  - Else: cnt <= 0.
  - Effect: a pulse on the raw input shorter than DEBOUNCE_CNT cycles (after sync) never changes the level. Any return to the old value restarts the count.
- Edge detect:
  - rise_x = level_x & ~level_x_d, where level_x_d is level delayed by one cycle.
  - Falling edges of the level produce no pulse.
- Output stage (registered):
  - s <= rise_set & ~rise_clr
  - r <= rise_clr & ~rise_set
  - conflict <= rise_set & rise_clr
- Invariants:
  - s and r are each high for exactly one cycle per accepted rise.
  - s & r is always 0.
  - conflict is never high together with s or r.
- Latency:
  - A clean, held 0->1 on set_in, first sampled at edge E, gives s=1 during the cycle after edge E + SYNC_STAGES + DEBOUNCE_CNT.
  - With defaults, s is high after edge E+6 and low again after edge E+7.
  - set_level rises one edge earlier than s.
- Held input:
  - A request held high indefinitely gives exactly one pulse.
  - A new pulse requires a debounced fall and then a debounced rise.
- Rises one or more cycles apart: both pulses are issued in order, s and r in separate cycles, with no conflict.
- Reset release with an input already high: the level rises after the normal latency and one pulse is issued. This is intended; it initialises the SR flip-flop to the input state.
- Reset mid-debounce or mid-pulse:
  - Everything clears immediately.
  - A pulse in flight is cancelled.
  - The counter restarts from 0 after release.
- Counter overflow is impossible: cnt never exceeds DEBOUNCE_CNT-1.

Test Plan:
1. Reset then clean press: res 0->1, set_in 0->1 held, defaults -> set_level=1 after edge 6, s=1 for exactly 1 cycle after edge 7, r=0 and conflict=0 throughout.
2. Bounce filter: clr_in toggled high 3 cycles / low 1 / high 2 / low, with DEBOUNCE_CNT=4 -> clr_level stays 0, r never pulses. Then held high for 10 cycles -> exactly one r pulse.
3. Simultaneous request: set_in and clr_in rise on the same edge and are held -> conflict=1 for one cycle, s=0 and r=0 for the whole run, both levels=1.
4. Staggered requests: set_in rises, clr_in rises 2 cycles later -> s pulse, then r pulse 2 cycles later, never overlapping, conflict=0.
5. Async reset mid-operation: set_in held high, res driven 0 between clk edges at edge 4 -> all outputs are 0 immediately with no clk edge needed. After release with set_in still high -> one s pulse, 7 edges after release.
6. Invariant check across random bouncing stimulus (10k cycles, random SYNC_STAGES 2..3, DEBOUNCE_CNT 1..8) -> s&r is never 1; the number of s pulses equals the number of set_level rises not coinciding with a clr_level rise.
